// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - AHB-Lite codes, SRAM FSM states and byte-enable helper
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  // An all-zero result marks an unsupported size.
  function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: be = 4'b0011 << {addr[1], 1'b0};
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_be_sdp.sv
// rtl/sram_be_sdp.sv - simple dual-port word array, byte-enable write, synchronous read
module sram_be_sdp #(
  parameter int AW        = 12,
  parameter     INIT_FILE = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wbe,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] rdata_q;

  // Read-during-write returns the old word; the caller forwards new lanes itself.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ahb_lite_sram_be.sv
// rtl/ahb_lite_sram_be.sv - AHB-Lite SRAM subordinate with byte lanes, read wait states,
// write-to-read forwarding and two-cycle ERROR response
module ahb_lite_sram_be
  import ahb_lite_pkg::*;
#(
  parameter int MEMWIDTH    = 14,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         AW = MEMWIDTH - 2;
  localparam logic [1:0] WS = 2'(WAIT_STATES);

  sram_state_e   state_q, state_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]    wr_be_q, wr_be_d;
  logic          rd_act_q, rd_act_d;
  logic [3:0]    fwd_be_q, fwd_be_d;
  logic [31:0]   fwd_data_q, fwd_data_d;
  logic [31:0]   hrdata_q, hrdata_d;

  logic          accept, illegal, legal_rd, legal_wr;
  logic [3:0]    be;
  logic [AW-1:0] word_addr;
  logic [31:0]   mem_rdata, rd_merged;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:MEMWIDTH], HTRANS[0]};

  assign word_addr = HADDR[MEMWIDTH-1:2];
  assign be        = be_from_size(HSIZE, HADDR[1:0]);
  assign illegal   = (be == 4'b0000)
                   || ((HSIZE == HSIZE_HALF) && HADDR[0])
                   || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
  assign accept    = HSEL && HREADY && HTRANS[1];
  assign legal_rd  = accept && !illegal && !HWRITE;
  assign legal_wr  = accept && !illegal && HWRITE;

  always_comb begin
    HREADYOUT = 1'b1;
    if (state_q == ST_ERR1) HREADYOUT = 1'b0;
    else if (state_q == ST_DATA) HREADYOUT = (wait_cnt_q == 2'd0);
  end

  assign HRESP = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  // Lanes written by the write whose data phase overlapped the read's address phase
  always_comb begin
    rd_merged = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (fwd_be_q[i]) rd_merged[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  assign HRDATA = rd_act_q ? rd_merged : hrdata_q;

  always_comb begin
    state_d    = ST_IDLE;
    wait_cnt_d = 2'd0;
    if (accept && illegal) begin
      state_d = ST_ERR1;
    end else if (legal_rd && (WS != 2'd0)) begin
      state_d    = ST_DATA;
      wait_cnt_d = WS;
    end else if (!accept) begin
      if (state_q == ST_ERR1) begin
        state_d = ST_ERR2;
      end else if ((state_q == ST_DATA) && (wait_cnt_q != 2'd0)) begin
        state_d    = ST_DATA;
        wait_cnt_d = wait_cnt_q - 2'd1;
      end
    end
  end

  always_comb begin
    wr_pend_d  = legal_wr;
    wr_addr_d  = legal_wr ? word_addr : wr_addr_q;
    wr_be_d    = legal_wr ? be : wr_be_q;
    rd_act_d   = HREADYOUT ? legal_rd : rd_act_q;
    hrdata_d   = (rd_act_q && HREADYOUT) ? rd_merged : hrdata_q;
    fwd_be_d   = fwd_be_q;
    fwd_data_d = fwd_data_q;
    if (legal_rd) begin
      fwd_be_d   = (wr_pend_q && (wr_addr_q == word_addr)) ? wr_be_q : 4'b0000;
      fwd_data_d = HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 2'd0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_be_q    <= 4'b0000;
      rd_act_q   <= 1'b0;
      fwd_be_q   <= 4'b0000;
      fwd_data_q <= 32'h0;
      hrdata_q   <= 32'h0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_be_q    <= wr_be_d;
      rd_act_q   <= rd_act_d;
      fwd_be_q   <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
      hrdata_q   <= hrdata_d;
    end
  end

  sram_be_sdp #(
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (HCLK),
    .we    (wr_pend_q),
    .waddr (wr_addr_q),
    .wbe   (wr_be_q),
    .wdata (HWDATA),
    .re    (legal_rd),
    .raddr (word_addr),
    .rdata (mem_rdata)
  );

endmodule
